// File: rtl/cf_response_checker.sv
// cf_response_checker: sweeps all 32 codes into a 5-input DUT, captures y and checks it against EXP_TT
module cf_response_checker #(
    parameter int          SETTLE = 2,
    parameter logic [31:0] EXP_TT = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [4:0]  vec,
    input  logic        y,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [31:0] captured,
    output logic [5:0]  mismatch_count,
    output logic [4:0]  first_fail_idx,
    output logic        first_fail_valid
);
    typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;
    state_t state, state_nx;
    logic [3:0] cnt;
    logic miss;
    assign miss = y != EXP_TT[vec];
    always_ff @(posedge clk)
        state <= !rst_n ? IDLE : state_nx;
    always_comb begin
        state_nx = state;
        busy = 1'b0;
        done = 1'b0;
        unique case (state)
            IDLE: state_nx = start ? APPLY : IDLE;
            APPLY: begin
                busy = 1'b1;
                state_nx = cnt == 4'(SETTLE - 1) ? SAMPLE : APPLY;
            end
            SAMPLE: begin
                busy = 1'b1;
                state_nx = &vec ? DONE : APPLY;
            end
            default: begin
                done = 1'b1;
                state_nx = IDLE;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vec <= '0;
            cnt <= '0;
            pass <= 1'b0;
            captured <= '0;
            mismatch_count <= '0;
            first_fail_idx <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    vec <= '0;
                    cnt <= '0;
                    pass <= 1'b0;
                    captured <= '0;
                    mismatch_count <= '0;
                    first_fail_idx <= '0;
                    first_fail_valid <= 1'b0;
                end
                APPLY: cnt <= cnt + 4'd1;
                SAMPLE: begin
                    captured[vec] <= y;
                    if (miss) begin
                        mismatch_count <= mismatch_count + 6'd1;
                        if (!first_fail_valid) begin
                            first_fail_idx <= vec;
                            first_fail_valid <= 1'b1;
                        end
                    end
                    if (!(&vec)) begin
                        vec <= vec + 5'd1;
                        cnt <= '0;
                    end
                end
                default: pass <= mismatch_count == 6'd0;
            endcase
        end
    end
endmodule

// File: tb/tb_cf_response_checker.sv
// tb_cf_response_checker: random and directed runs of two checkers against a cycle-level behavioural model
module tb_cf_response_checker;
    localparam logic [31:0] EXP = 32'hA5A5_F00F;
    localparam int S0 = 2;
    localparam int S1 = 5;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [31:0] tt = EXP;
    logic [4:0]  vec_d [2];
    logic        y_d [2];
    logic        busy_d [2];
    logic        done_d [2];
    logic        pass_d [2];
    logic [31:0] cap_d [2];
    logic [5:0]  mc_d [2];
    logic [4:0]  ffi_d [2];
    logic        ffv_d [2];
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;

    cf_response_checker #(.SETTLE(S0), .EXP_TT(EXP)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .vec(vec_d[0]), .y(y_d[0]),
        .busy(busy_d[0]), .done(done_d[0]), .pass(pass_d[0]), .captured(cap_d[0]),
        .mismatch_count(mc_d[0]), .first_fail_idx(ffi_d[0]), .first_fail_valid(ffv_d[0]));
    cf_response_checker #(.SETTLE(S1), .EXP_TT(EXP)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .vec(vec_d[1]), .y(y_d[1]),
        .busy(busy_d[1]), .done(done_d[1]), .pass(pass_d[1]), .captured(cap_d[1]),
        .mismatch_count(mc_d[1]), .first_fail_idx(ffi_d[1]), .first_fail_valid(ffv_d[1]));

    // DUT models: u0 sees y glitch for one cycle after each vec change, u1 sees y lag vec by 4 cycles
    logic noise = 1'b0;
    logic [4:0] v0_q = '0;
    logic [4:0] h [4] = '{default: '0};
    always @(posedge clk) begin
        noise <= 1'($urandom);
        v0_q <= vec_d[0];
        h[0] <= vec_d[1];
        h[1] <= h[0];
        h[2] <= h[1];
        h[3] <= h[2];
    end
    assign y_d[0] = tt[vec_d[0]] ^ (vec_d[0] != v0_q && noise);
    assign y_d[1] = tt[h[3]];

    bit act [2];
    bit ran [2];
    int k [2];
    int e0 [2];
    int done_edge [2];
    logic [31:0] rtt [2];
    int cyc = 0;

    function automatic int per(input int i);
        return i != 0 ? S1 + 1 : S0 + 1;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                act[i] = 0; ran[i] = 0; k[i] = 0;
            end else if (!act[i]) begin
                if (start) begin
                    act[i] = 1; ran[i] = 1; k[i] = 0; rtt[i] = tt; e0[i] = cyc;
                end
            end else begin
                k[i]++;
                if (k[i] == 32 * per(i) + 1) act[i] = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic cmp(input int i);
        automatic int p = per(i);
        automatic int l = 32 * p;
        automatic int n = ran[i] ? (k[i] / p > 32 ? 32 : k[i] / p) : 0;
        automatic logic [63:0] m = (64'd1 << n) - 64'd1;
        automatic logic [31:0] diff = (rtt[i] ^ EXP) & m[31:0];
        automatic int ffi = 0;
        automatic int ev = ran[i] ? (k[i] / p > 31 ? 31 : k[i] / p) : 0;
        for (int j = 31; j >= 0; j--) if (diff[j]) ffi = j;
        if (done_d[i]) done_edge[i] = cyc;
        chk($sformatf("u%0d.vec", i), 64'(vec_d[i]), 64'(ev));
        chk($sformatf("u%0d.busy", i), 64'(busy_d[i]), 64'(act[i] && k[i] < l));
        chk($sformatf("u%0d.done", i), 64'(done_d[i]), 64'(act[i] && k[i] == l));
        chk($sformatf("u%0d.pass", i), 64'(pass_d[i]), 64'(ran[i] && !act[i] && diff == 0));
        chk($sformatf("u%0d.captured", i), 64'(cap_d[i]), 64'(rtt[i] & m[31:0]));
        chk($sformatf("u%0d.mismatch_count", i), 64'(mc_d[i]), 64'($countones(diff)));
        chk($sformatf("u%0d.first_fail_idx", i), 64'(ffi_d[i]), 64'(ffi));
        chk($sformatf("u%0d.first_fail_valid", i), 64'(ffv_d[i]), 64'(diff != 0));
    endtask

    initial forever begin
        @(negedge clk);
        cmp(0);
        cmp(1);
    end

    task automatic lits(input int i, input logic [31:0] c, input logic [5:0] mc, input logic [4:0] f,
                        input bit v, input bit p, input int lat);
        chk($sformatf("lit u%0d captured", i), 64'(cap_d[i]), 64'(c));
        chk($sformatf("lit u%0d mismatch_count", i), 64'(mc_d[i]), 64'(mc));
        chk($sformatf("lit u%0d first_fail_idx", i), 64'(ffi_d[i]), 64'(f));
        chk($sformatf("lit u%0d first_fail_valid", i), 64'(ffv_d[i]), 64'(v));
        chk($sformatf("lit u%0d pass", i), 64'(pass_d[i]), 64'(p));
        if (lat > 0) chk($sformatf("lit u%0d done latency", i), 64'(done_edge[i] - e0[i]), 64'(lat));
    endtask

    task automatic pulse();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic run(input logic [31:0] t, input bit poke);
        tt = t;
        pulse();
        if (poke) begin
            repeat (9) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        for (int c = 0; c < 1000 && (act[0] || act[1]); c++) begin
            @(posedge clk); #1;
        end
        chk("run completes", {62'd0, act[0], act[1]}, 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not end, errors %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) lits(i, 32'h0, 6'd0, 5'd0, 1'b0, 1'b0, 0);
        run(EXP, 0);
        lits(0, 32'hA5A5_F00F, 6'd0, 5'd0, 1'b0, 1'b1, 96);
        lits(1, 32'hA5A5_F00F, 6'd0, 5'd0, 1'b0, 1'b1, 192);
        run(EXP, 1);
        lits(0, 32'hA5A5_F00F, 6'd0, 5'd0, 1'b0, 1'b1, 96);
        run(EXP ^ 32'h0008_0000, 0);
        lits(0, 32'hA5AD_F00F, 6'd1, 5'd19, 1'b1, 1'b0, 96);
        lits(1, 32'hA5AD_F00F, 6'd1, 5'd19, 1'b1, 1'b0, 192);
        run(~EXP, 0);
        lits(0, 32'h5A5A_0FF0, 6'd32, 5'd0, 1'b1, 1'b0, 96);
        tt = EXP;
        pulse();
        repeat (39) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            lits(i, 32'h0, 6'd0, 5'd0, 1'b0, 1'b0, 0);
            chk($sformatf("lit u%0d vec after reset", i), 64'(vec_d[i]), 64'd0);
            chk($sformatf("lit u%0d busy after reset", i), 64'(busy_d[i]), 64'd0);
        end
        run(EXP, 0);
        lits(0, 32'hA5A5_F00F, 6'd0, 5'd0, 1'b0, 1'b1, 96);
        lits(1, 32'hA5A5_F00F, 6'd0, 5'd0, 1'b0, 1'b1, 192);
        repeat (4) run($urandom, 1'($urandom));
        repeat (4000) begin
            @(posedge clk); #1;
            if (!act[0] && !act[1] && $urandom_range(3) == 0) tt = $urandom;
            start = $urandom_range(39) == 0;
            rst_n = $urandom_range(699) != 0;
        end
        rst_n = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cf_response_checker.md
# cf_response_checker

Self-checking response analyser for the 5-input combinational function blocks under test. It drives all 32 input codes to the DUT in a fixed order and waits a programmable settle time per code. It samples the DUT's single-bit output into a 32-bit captured truth table and compares each sample against an expected truth table. It sits beside the DUT in hardware test wrappers, and reports pass/fail plus the first failing code.

## Interface
Parameters:
- SETTLE, default 2: cycles each vector is held before sampling; legal range 1..15.
- EXP_TT, default 32'h0000_0000: expected truth table; bit i is the expected y for input code i.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  begin a run; sampled only in IDLE.
- vec  out  5  DUT input code, registered; vec[4]=e, vec[3]=a, vec[2]=b, vec[1]=c, vec[0]=d.
- y  in  1  DUT output, sampled in SAMPLE state.
- busy  out  1  high from the cycle after start is accepted until DONE is entered.
- done  out  1  one-cycle pulse at end of run.
- pass  out  1  1 when the last completed run had zero mismatches; held until the next start.
- captured  out  32  captured truth table; bit i = y sampled for code i.
- mismatch_count  out  6  number of codes with y != EXP_TT[i], range 0..32.
- first_fail_idx  out  5  lowest failing code; valid when first_fail_valid=1.
- first_fail_valid  out  1  at least one mismatch recorded in the current or last run.

## Operation
- States: IDLE, APPLY, SAMPLE, DONE.
- IDLE: when start=1, clear captured, mismatch_count, first_fail_idx, first_fail_valid and pass. Set idx=0, vec=0, settle counter=0, then go to APPLY.
- APPLY: vec=idx held stable. The settle counter increments each cycle. After SETTLE cycles in APPLY, go to SAMPLE.
- SAMPLE, one cycle, vec unchanged:
  - On the closing edge, captured[idx]<=y.
  - If y != EXP_TT[idx]: mismatch_count+1. If first_fail_valid=0, also set first_fail_idx<=idx and first_fail_valid<=1.
  - If idx=31, go to DONE. Otherwise idx+1, vec<=idx+1, settle counter=0, go to APPLY.
- DONE, one cycle: done=1, busy=0, and pass<=(mismatch_count==0), using the final count including code 31. Then go to IDLE.
- The code order is 0..31 ascending: e=0 for codes 0-15 and e=1 for codes 16-31.
- start outside IDLE is ignored; there is no queuing. start held high through DONE launches a new run on the IDLE cycle after it.
- Result outputs (captured, mismatch_count, first_fail_*, pass) hold their values in IDLE until the next accepted start.
- vec holds its last value (31) after a run completes, until the next start.

## Timing
- Reset (rst_n=0 at a rising edge): state=IDLE. vec=0, busy=0, done=0, pass=0, captured=0, mismatch_count=0, first_fail_idx=0, first_fail_valid=0.
- Reset mid-run aborts immediately to the reset values. No partial done or pass is produced.
- Edge E0 is the edge at which start=1 is seen in IDLE. busy=1 and vec=0 are visible after E0.
- Each code occupies SETTLE+1 cycles. y for code i is sampled at edge E0+(i+1)(SETTLE+1).
- done is high in the cycle following edge E0+32(SETTLE+1). With SETTLE=2 that is E96.
- busy falls with done, in the same cycle. The earliest next start is accepted 2 cycles after E0+32(SETTLE+1).
- mismatch_count saturates naturally at 32, since there are at most 32 codes; 6 bits are needed.
- y is assumed combinationally settled within SETTLE cycles of a vec change. Values of y outside SAMPLE are ignored.

## Test plan
- Reset, then start with the DUT model equal to EXP_TT=32'hA5A5_F00F, SETTLE=2:
  - vec steps 0..31, each held 3 cycles.
  - done is high in cycle E0+96.
  - Expect captured=32'hA5A5_F00F, mismatch_count=0, pass=1, first_fail_valid=0.
- DUT model with only code 19 inverted: mismatch_count=1, first_fail_idx=19, first_fail_valid=1, pass=0, captured=EXP_TT^32'h0008_0000.
- DUT model fully inverted: mismatch_count=32, first_fail_idx=0, pass=0, captured=~EXP_TT.
- Pulse start again at E0+10 during busy: ignored. The run timing and results are identical to the single-start case.
- Deassert rst_n for one cycle at E0+40: all outputs return to reset values and state=IDLE. A fresh start then completes normally with correct results.
- SETTLE=5 with a DUT model whose y lags vec by 4 cycles: pass=1, and done is high in cycle E0+192.
